feature_window_seq: RTL
=======================

// Module: feature_window_seq
// PURPOSE
// Parametrised feature-window sequencer. It replaces the single-shot combinational window calculator.
// Accepts one job (start point, total feature count) and emits a sequence of half-open windows [win_lo, win_hi).
// Each window is at most SIMD_NUM*LANE_NUM features. The final window is clamped to the total.
// Sits between the layer controller and the feature fetch unit. Windows are issued over a valid/ready handshake.
// PARAMETERS
// SIMD_NUM  64  SIMD units per lane
// LANE_NUM  32  lanes; window length WIN = SIMD_NUM*LANE_NUM (default 2048)
// AW        12  feature index width; WIN <= 2**AW required (elaboration error otherwise)
// PORTS
// clk        in   1   clock, rising edge
// rst_n      in   1   synchronous active-low reset
// cfg_valid  in   1   job request valid
// cfg_ready  out  1   job accepted when cfg_valid&&cfg_ready
// cfg_ini    in   1   1: start index 0; 0: start index cfg_base
// cfg_base   in   AW  start index when cfg_ini=0 (previous job's end)
// cfg_total  in   AW  exclusive upper bound of feature range
// abort      in   1   cancel current job
// win_valid  out  1   window valid
// win_ready  in   1   consumer accepts window
// win_lo     out  AW  window first index (inclusive)
// win_hi     out  AW  window end index (exclusive)
// win_last   out  1   this window reaches cfg_total
// done       out  1   1-cycle pulse after last window accepted or abort
// err        out  1   1-cycle pulse: job rejected (start >= total)
// busy       out  1   state != IDLE
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state=IDLE, cur=0, total=0, win_valid=0, win_lo=0, win_hi=0.
//   Also win_last=0, done=0, err=0, busy=0. Reset dominates all other inputs, including mid-job.
// - cfg_ready = (state==IDLE). cfg_* is ignored outside IDLE.
// - State IDLE: on accept, start = cfg_ini ? 0 : cfg_base. Total is latched.
//   If start >= cfg_total (including cfg_total==0): err=1 next cycle, stay IDLE.
//   Otherwise: cur=start, go to RUN.
// - State RUN: outputs are registered. win_valid=1 from the cycle after accept (latency 1).
//   win_lo=cur; win_hi=min(cur+WIN, total); win_last=(cur+WIN >= total).
// - Sum cur+WIN is computed in AW+1 bits. There is no wrap-around; win_hi never exceeds total.
// - Outputs hold stable while win_valid && !win_ready.
// - On win_valid&&win_ready with !win_last: cur += WIN. The next window is valid the following cycle (no bubble).
// - On win_valid&&win_ready with win_last: go to IDLE, win_valid=0, done=1 for 1 cycle.
//   cfg_ready=1 in that same next cycle.
// - abort in RUN: go to IDLE next cycle, win_valid=0, done=1. A handshake in the same cycle as abort is honoured,
//   but no further window is issued. abort in IDLE is ignored.
// - done and err never assert together. busy = (state==RUN).
// TESTING
// 1 cfg_ini=1, cfg_total=4095, win_ready=1 -> [0,2048) last=0; [2048,4095) last=1; done pulse; 2 windows only.
// 2 cfg_ini=0, base=1000, total=3000 -> single window [1000,3000), last=1, latency 1 cycle after accept.
// 3 cfg_ini=0, base=3000, total=3000, and separately total=0 -> err pulse, no win_valid, cfg_ready stays 1.
// 4 Job of test 1 with win_ready low 5 cycles -> win_lo=0/win_hi=2048 held stable; cfg_valid ignored while busy.
// 5 abort during the 1st window of test 1 -> win_valid=0 and done=1 next cycle; a new job is accepted right after.
// 6 rst_n=0 mid-RUN, then new job base=0 total=100 -> all outputs 0 after reset; then window [0,100) last=1.

Source files
------------

// File: rtl/feature_window_seq.sv
// Feature-window sequencer: turns one (start, total) job into a stream of
// half-open windows [win_lo, win_hi) of at most SIMD_NUM*LANE_NUM features.
module feature_window_seq #(
  parameter int SIMD_NUM = 64,
  parameter int LANE_NUM = 32,
  parameter int AW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic          cfg_ini,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW-1:0] cfg_total,
  input  logic          abort,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [AW-1:0] win_lo,
  output logic [AW-1:0] win_hi,
  output logic          win_last,
  output logic          done,
  output logic          err,
  output logic          busy
);

  localparam int WIN = SIMD_NUM * LANE_NUM;
  localparam logic [AW:0] WIN_EXT = (AW+1)'(WIN);

  if (WIN > (2 ** AW)) begin : g_win_too_wide
    $error("feature_window_seq: SIMD_NUM*LANE_NUM exceeds 2**AW");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] cur;
  logic [AW-1:0] total;
  logic [AW-1:0] start;
  logic [AW-1:0] next_lo;
  logic [AW:0]   first_end;
  logic [AW:0]   next_end;

  // Returns {last, hi}; the sum is one bit wider so it can never wrap past total.
  function automatic logic [AW:0] win_end(input logic [AW-1:0] lo, input logic [AW-1:0] tot);
    logic [AW:0] sum;
    sum = {1'b0, lo} + WIN_EXT;
    if (sum >= {1'b0, tot}) begin
      win_end = {1'b1, tot};
    end else begin
      win_end = {1'b0, sum[AW-1:0]};
    end
  endfunction

  assign start     = cfg_ini ? {AW{1'b0}} : cfg_base;
  // Only used when the current window is not last, so cur+WIN < total fits in AW bits.
  assign next_lo   = cur + AW'(WIN);
  assign first_end = win_end(start, cfg_total);
  assign next_end  = win_end(next_lo, total);
  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);

  // Job sequencing FSM with registered window outputs and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= {AW{1'b0}};
      total     <= {AW{1'b0}};
      win_valid <= 1'b0;
      win_lo    <= {AW{1'b0}};
      win_hi    <= {AW{1'b0}};
      win_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            total <= cfg_total;
            if (start >= cfg_total) begin
              err <= 1'b1;
            end else begin
              cur       <= start;
              win_valid <= 1'b1;
              win_lo    <= start;
              win_hi    <= first_end[AW-1:0];
              win_last  <= first_end[AW];
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (abort || (win_valid && win_ready && win_last)) begin
            win_valid <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (win_valid && win_ready) begin
            cur      <= next_lo;
            win_lo   <= next_lo;
            win_hi   <= next_end[AW-1:0];
            win_last <= next_end[AW];
          end
        end
        default: begin
          state     <= IDLE;
          win_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
